uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Transmit half of the UART APB peripheral, the counterpart of the receive FIFO path. Bytes written from the APB side are buffered in a small internal FIFO, then serialized LSB-first onto the `tx` line as 8N1/8E1/8O1/8N2 frames paced by a 16x oversampling baud tick. It sits between the APB register block (write side) and the pad (serial side). It reports FIFO status and per-frame completion back to the register block.

## Interface
- `DEPTH`, 4: transmit FIFO entries.
- `ADDR_WIDTH`, 2: pointer width; DEPTH == 2**ADDR_WIDTH.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `wr_en`  in  1  push request, level from APB; one push per rising edge.
- `data_in`  in  8  byte to push, sampled on the wr_en rising-edge cycle.
- `baud_tick`  in  1  one-clk pulse at 16x the baud rate.
- `parity_en`  in  1  1 = append parity bit.
- `parity_odd`  in  1  1 = odd parity, 0 = even parity.
- `two_stop`  in  1  1 = two stop bits.
- `tx`  out  1  serial output, registered; idle high.
- `full`  out  1  FIFO count == DEPTH.
- `empty`  out  1  FIFO count == 0.
- `busy`  out  1  FSM not in IDLE.
- `tx_done`  out  1  one-clk pulse at the end of each frame.

## Operation
- Push edge detect: wr_en_d is a register of wr_en. Push = wr_en & ~wr_en_d & ~full. Holding wr_en high pushes exactly once. A push while full is dropped silently.
- FIFO: mem[wr_ptr] <= data_in and wr_ptr++ on push. The pointers wrap modulo DEPTH. count is ADDR_WIDTH+1 bits.
- Pop: occurs only in IDLE when ~empty. It loads shift_reg <= mem[rd_ptr] and increments rd_ptr.
- Simultaneous push and pop: count stays unchanged, both pointers advance. A push into an empty FIFO is not visible for a pop until the following cycle.
- Frame config: parity_en, parity_odd and two_stop are latched at pop. Changes during a frame have no effect on that frame.
- Parity bit = ^data XOR parity_odd.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE → START on pop.
  - START → DATA after 1 bit time.
  - DATA stays for 8 bit times, shifting LSB first; bit_idx counts 0..7. Then → PARITY if parity_en, else → STOP1.
  - PARITY → STOP1 after 1 bit time.
  - STOP1 → STOP2 if two_stop, else → IDLE.
  - STOP2 → IDLE.
- Bit time: 4-bit tick_cnt, cleared on state entry, increments on baud_tick. A bit ends on the cycle the 16th baud_tick is seen (tick_cnt == 15 && baud_tick).
- tx values per state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift_reg[0].
  - PARITY: the parity bit.
  - STOP1/STOP2: 1.
- tx_done pulses on the cycle the final stop bit ends, i.e. the same edge that enters IDLE.

## Timing
- Reset values: tx=1, full=0, empty=1, busy=0, tx_done=0. All pointers, count, tick_cnt, bit_idx, wr_en_d and shift_reg are 0. FSM is in IDLE.
- Reset asserted mid-frame: tx returns to 1 asynchronously, FIFO contents are discarded, and no tx_done is produced.
- Pop latency: with a pop in cycle N, tx=0 and busy=1 from edge N+1.
- Frame length: 16 × (10 + parity_en + two_stop) baud_ticks.
- Back-to-back frames: after tx_done, the FSM spends exactly one clk cycle in IDLE with tx=1, then pops if ~empty.
- full/empty are combinational from count and update the cycle after the push or pop.
- baud_tick is ignored in IDLE. tick_cnt does not advance without baud_tick.

## Test plan
- Single frame: push 0x55 with parity_en=0 and two_stop=0. Required: tx = 0,1,0,1,0,1,0,1,0,1, each bit lasting 16 baud_ticks. tx_done pulses once and busy falls on the same edge.
- Parity: push 0x07 with even parity. Required: parity bit = 1. Repeat with odd parity. Required: parity bit = 0. In both cases the frame spans 176 ticks.
- Two stop bits: push 0xA3 with two_stop=1. Required: tx stays high for 32 ticks after the last data bit before tx_done.
- Fill/overflow:
  - Stimulus: 6 distinct wr_en pulses (0x01..0x06) in quick succession.
  - Required: 0x01 is popped immediately, and 0x02..0x05 fill the FIFO (full=1). 0x06 is dropped.
  - Required: the serial output carries 0x01..0x05 in order, each separated by one idle clk, then empty=1 and busy=0.
- Level-held wr_en: hold wr_en high for 20 cycles with data_in=0x3C. Required: exactly one frame is transmitted.
- Reset mid-frame: assert rst during the DATA state with 2 bytes queued. Required: tx=1 immediately, empty=1, no tx_done, and no transmission after rst is released.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmitter: 4-entry byte FIFO feeding an 8N1/8E1/8O1/8N2 serializer paced by a 16x baud tick.
// Latency: a pop in cycle N drives the start bit (tx=0) and busy=1 from edge N+1; each bit lasts 16 baud ticks.
// Backpressure: full reflects the FIFO count; a push while full is dropped silently.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   wr_en, data_in           push request (edge-detected) and the byte to push
//   baud_tick                one-clk pulse at 16x the baud rate
//   parity_en, parity_odd,   frame configuration, latched when a byte is popped
//   two_stop
//   tx                       registered serial output, idle high
//   full, empty, busy        FIFO status and "frame in progress"
//   tx_done                  one-clk pulse on the edge that ends the final stop bit
module uart_tx_engine #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] data_in,
    input  logic       baud_tick,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       two_stop,
    output logic       tx,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP1  = 3'd4;
    localparam logic [2:0] STOP2  = 3'd5;

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_en_d;
    logic                  push;
    logic                  pop;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [3:0]            tick_cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shift_reg;
    logic [7:0]            shift_nxt;
    logic                  par_en_l;
    logic                  two_stop_l;
    logic                  par_bit;
    logic                  bit_end;
    logic                  last_stop;
    logic                  tx_nxt;

    assign full      = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state != IDLE);
    assign push      = wr_en & ~wr_en_d & ~full;
    assign pop       = (state == IDLE) & ~empty;
    // A bit ends on the cycle the 16th baud tick of that bit is seen.
    assign bit_end   = busy & baud_tick & (tick_cnt == 4'd15);
    assign last_stop = bit_end & (((state == STOP1) & ~two_stop_l) | (state == STOP2));

    // FIFO bookkeeping; count only moves when exactly one of push/pop happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_d <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            wr_en_d <= wr_en;
            if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({push, pop})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only readable once pushed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = START;
                    shift_nxt = mem[rd_ptr];
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) state_nxt = par_en_l ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP1;
            end
            STOP1: begin
                if (bit_end) state_nxt = two_stop_l ? STOP2 : IDLE;
            end
            STOP2: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx is registered, so it is derived from the state being entered.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = par_bit;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            par_en_l   <= 1'b0;
            two_stop_l <= 1'b0;
            par_bit    <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            tx        <= tx_nxt;
            tx_done   <= last_stop;
            // tick_cnt wraps 15->0 exactly at each bit boundary, so it is
            // already clear on entry to every state after START.
            if (pop) begin
                tick_cnt <= '0;
            end else if (busy & baud_tick) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
            if (pop) begin
                bit_idx <= '0;
            end else if ((state == DATA) & bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            // Frame configuration and parity are frozen for the whole frame.
            if (pop) begin
                par_en_l   <= parity_en;
                two_stop_l <= two_stop;
                par_bit    <= (^mem[rd_ptr]) ^ parity_odd;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       baud_tick;
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;
    logic       tx;
    logic       full;
    logic       empty;
    logic       busy;
    logic       tx_done;

    uart_tx_engine #(.DEPTH(4), .ADDR_WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .baud_tick  (baud_tick),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .tx         (tx),
        .full       (full),
        .empty      (empty),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Baud tick: random pulses, about two ticks in three clocks.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1 baud_tick = ($urandom_range(0, 2) != 0);
        end
    end

    // Line monitor: turns each busy window into a record of per-bit tx values.
    typedef struct {
        logic [11:0] bits;
        int          ticks;
        bit          glitch;
        logic        done;
        logic        tx_end;
        int          gap;
    } frm_t;

    frm_t        obs_q[$];
    int          done_cnt = 0;
    bit          in_frame;
    int          idle_cnt;
    int          cur_gap;
    int          mticks;
    logic [11:0] mbits;
    bit          mglitch;

    initial begin
        frm_t rec;
        int   bi;
        in_frame = 0;
        idle_cnt = 0;
        cur_gap  = 0;
        mticks   = 0;
        mbits    = '0;
        mglitch  = 0;
        forever begin
            @(negedge clk);
            if (tx_done === 1'b1) done_cnt++;
            if (rst) begin
                in_frame = 0;
                idle_cnt = 0;
            end else if (busy) begin
                if (!in_frame) begin
                    in_frame = 1;
                    cur_gap  = idle_cnt;
                    mticks   = 0;
                    mbits    = '0;
                    mglitch  = 0;
                end
                idle_cnt = 0;
                if (baud_tick) begin
                    if (mticks < 192) begin
                        bi = mticks / 16;
                        if (mticks % 16 == 0) mbits[bi] = tx;
                        else if (mbits[bi] !== tx) mglitch = 1;
                    end
                    mticks++;
                end
            end else begin
                if (in_frame) begin
                    rec.bits   = mbits;
                    rec.ticks  = mticks;
                    rec.glitch = mglitch;
                    rec.done   = tx_done;
                    rec.tx_end = tx;
                    rec.gap    = cur_gap;
                    obs_q.push_back(rec);
                    in_frame = 0;
                end
                idle_cnt++;
            end
        end
    end

    // Reference frame: start, 8 data bits LSB first, optional parity, stop bit(s).
    function automatic int frame_len(input bit pe, input bit ts);
        return 10 + int'(pe) + int'(ts);
    endfunction

    function automatic logic [11:0] frame_bits(input logic [7:0] d, input bit pe, input bit po, input bit ts);
        logic [11:0] f;
        int          n;
        n = frame_len(pe, ts);
        f = '0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        if (pe) f[9] = ((^d) ^ po);
        for (int i = (pe ? 10 : 9); i < n; i++) f[i] = 1'b1;
        return f;
    endfunction

    task automatic expect_frame(input logic [7:0] d, input bit pe, input bit po, input bit ts, input bit chk_gap);
        frm_t        r;
        logic [11:0] m;
        int          n;
        int          waited;
        waited = 0;
        while (obs_q.size() == 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (obs_q.size() == 0) begin
            check("frame_timeout", 32'd0, 32'd1);
            return;
        end
        r = obs_q.pop_front();
        n = frame_len(pe, ts);
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        check($sformatf("bits_%02h", d), {20'd0, r.bits & m}, {20'd0, frame_bits(d, pe, po, ts)});
        check($sformatf("ticks_%02h", d), r.ticks, 16 * n);
        check($sformatf("stable_%02h", d), {31'd0, r.glitch}, 32'd0);
        check($sformatf("done_at_end_%02h", d), {31'd0, r.done}, 32'd1);
        check($sformatf("tx_idle_%02h", d), {31'd0, r.tx_end}, 32'd1);
        if (chk_gap) check($sformatf("gap_%02h", d), r.gap, 1);
    endtask

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        data_in = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic set_cfg(input bit pe, input bit po, input bit ts);
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
    endtask

    task automatic wait_busy();
        int w;
        w = 0;
        while (busy !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (busy !== 1'b1) check("busy_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_empty"}, {31'd0, empty}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] bytes [6];
        int         k;
        bit         pe, po, ts;
        int         dc;
        int         tk;

        rst     = 1'b1;
        wr_en   = 1'b0;
        data_in = 8'h00;
        set_cfg(0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_no_frame", obs_q.size(), 0);

        // Single 8N1 frame
        push_byte(8'h55);
        expect_frame(8'h55, 0, 0, 0, 0);
        check_idle("single");
        check("single_done_pulses", done_cnt, 1);

        // Even then odd parity on 0x07
        set_cfg(1, 0, 0);
        push_byte(8'h07);
        expect_frame(8'h07, 1, 0, 0, 0);
        set_cfg(1, 1, 0);
        push_byte(8'h07);
        expect_frame(8'h07, 1, 1, 0, 0);

        // Config changed mid-frame must not affect the frame in flight
        set_cfg(1, 0, 0);
        push_byte(8'h07);
        wait_busy();
        set_cfg(0, 1, 1);
        expect_frame(8'h07, 1, 0, 0, 0);

        // Two stop bits
        set_cfg(0, 0, 1);
        push_byte(8'hA3);
        expect_frame(8'hA3, 0, 0, 1, 0);

        // Fill and overflow
        set_cfg(0, 0, 0);
        for (int i = 1; i <= 6; i++) push_byte(8'(i));
        check("fill_full", {31'd0, full}, 32'd1);
        for (int i = 1; i <= 5; i++) expect_frame(8'(i), 0, 0, 0, i > 1);
        check_idle("fill");
        repeat (300) @(negedge clk);
        check("fill_dropped", obs_q.size(), 0);

        // Level-held wr_en pushes once
        @(negedge clk);
        wr_en   = 1'b1;
        data_in = 8'h3C;
        repeat (20) @(negedge clk);
        wr_en   = 1'b0;
        expect_frame(8'h3C, 0, 0, 0, 0);
        check_idle("level");
        repeat (50) @(negedge clk);
        check("level_single", obs_q.size(), 0);

        // Randomized bursts
        for (int it = 0; it < 6; it++) begin
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            ts = 1'($urandom_range(0, 1));
            set_cfg(pe, po, ts);
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) begin
                bytes[i] = 8'($urandom);
                push_byte(bytes[i]);
            end
            for (int i = 0; i < k && i < 5; i++) expect_frame(bytes[i], pe, po, ts, i > 0);
            check_idle($sformatf("burst%0d", it));
        end
        repeat (50) @(negedge clk);
        check("burst_no_extra", obs_q.size(), 0);

        // Reset in the middle of a data bit with two bytes queued
        set_cfg(0, 0, 0);
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'hFF);
        wait_busy();
        tk = 0;
        for (int w = 0; w < 1000 && tk < 40; w++) begin
            @(negedge clk);
            if (baud_tick && busy) tk++;
        end
        check("mid_tx_low", {31'd0, tx}, 32'd0);
        dc = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        check("mid_no_frame", obs_q.size(), 0);
        check("mid_no_done", done_cnt, dc);
        check_idle("mid_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
